mio_ram_arbiter: RTL and testbench
==================================

// Module: mio_ram_arbiter
// PURPOSE
//  Shares the single data-RAM port between two bus masters: m0 = SCPU data path (via MIO_BUS), m1 = DMA/debug loader.
//  Fixed priority to m0, with a starvation guard for m1. Serialises one word/byte-lane transaction at a time.
//  Handles RAM read latency and returns read data with a one-cycle ack pulse. Sits between the masters and RAM_B.
// PARAMETERS
//  AW        32  address width
//  DW        32  data width (byte enables = DW/8)
//  RD_LAT    1   cycles from RAM address presented (ISSUE) to ram_rdata valid; legal 1..8
//  MAX_WAIT  3   consecutive contested wins by m0 before m1 is forced through; legal 1..15
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous reset, active high
//  mN_req     in   1      (N=0,1) transaction request; hold with cmd stable until mN_ack
//  mN_we      in   1      1 = write, 0 = read
//  mN_addr    in   AW     byte address, passed through unchanged
//  mN_wdata   in   DW     write data
//  mN_be      in   DW/8   write byte enables
//  mN_gnt     out  1      high from ISSUE through ack cycle of mN's transaction
//  mN_ack     out  1      one-cycle completion pulse
//  mN_rdata   out  DW     read data, valid only in mN_ack cycle of a read
//  ram_addr   out  AW     latched address to RAM
//  ram_we     out  DW/8   byte write strobes, nonzero only in ISSUE of a write
//  ram_wdata  out  DW     latched write data
//  ram_rdata  in   DW     RAM read data
//  busy       out  1      state != IDLE
//  owner      out  1      index of current/last granted master
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; all gnt/ack/ram_we/busy/owner=0; ram_addr/ram_wdata/rdata regs=0; starve_cnt=0.
//  FSM: IDLE -> ISSUE -> (write) IDLE | (read) WAIT x(RD_LAT-1) -> RESP -> IDLE. Always one IDLE cycle between transactions.
//  IDLE: sample reqs; if any, latch winner's we/addr/wdata/be and owner at the edge, go ISSUE.
//  Arbitration: only one req -> it wins. Both -> m0 wins unless starve_cnt==MAX_WAIT, then m1 wins.
//  starve_cnt: +1 when both request and m0 wins; cleared when m1 wins or m1_req low in IDLE; saturates at MAX_WAIT.
//  ISSUE: gnt[owner]=1, ram_addr/ram_wdata = latched; ram_we = latched be if write else 0.
//   Write: ack[owner]=1 in ISSUE cycle; next cycle IDLE. Latency req-seen (cycle N) -> ack at N+1.
//   Read: ram_rdata captured into rdata reg at edge ending cycle ISSUE+RD_LAT-1; RESP next cycle with ack=1.
//   Read latency: req-seen N -> ack at N+1+RD_LAT (RD_LAT=1: ack N+2).
//  Write with be=0: normal transaction, ram_we stays 0, ack issued.
//  rdata reg shared; both mN_rdata show it; holds value until next read capture.
//  ram_addr/ram_wdata hold last latched value in IDLE; ram_we=0 outside ISSUE.
//  Req dropped before grant: no grant, no ack, no side effect. Req dropped after grant: protocol error; transaction still completes and acks.
//  Non-owner gnt/ack always 0. Reset mid-transaction: abandoned, no ack after release, RAM not written after reset asserts.
// STRUCTURE
//  mio_arb_pkg: state encoding localparams (IDLE, ISSUE, WAIT, RESP), master index constants M_CPU=0, M_DMA=1.
//  Sub-module mio_arb_prio: combinational winner select + starve_cnt register (clk, rst, req[1:0], fire -> win, starve_cnt).
//  Top: FSM, read-latency down-counter ($clog2(RD_LAT+1) bits), command latch, rdata reg.
// TESTING
//  1. RAM model RD_LAT=1, mem[0x10]=0xDEADBEEF; m0 read 0x10 at cycle 0 -> m0_gnt cyc1, ram_addr=0x10 cyc1, m0_ack+rdata=0xDEADBEEF cyc2 only.
//  2. m1 write addr 0x20, wdata 0x12345678, be=4'b0011 -> ram_we=4'b0011 cyc1 only, m1_ack cyc1, busy low cyc2; mem[0x20] low half updated.
//  3. MAX_WAIT=3, both hold write reqs continuously -> grant sequence m0,m0,m0,m1,m0,m0,m0,m1; starve_cnt returns to 0 after each m1.
//  4. m0 busy on read; m1_req pulses 1 cycle during WAIT -> m1_gnt/m1_ack never assert; no extra RAM write.
//  5. RD_LAT=3 m0 read -> ack exactly cycle 4; rst asserted in WAIT of a second read -> gnt/ack/busy 0 same cycle, no ack after release, next read served normally.
//  6. Write with be=0 by m1 -> ram_we stays 0, m1_ack cyc1; memory unchanged.

Source files
------------

// File: rtl/mio_arb_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM state encoding and master indices.
package mio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

endpackage

// File: rtl/mio_arb_prio.sv
// Fixed-priority winner select (m0 first) with a saturating starvation guard for m1.
module mio_arb_prio
  import mio_arb_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       fire,
  output logic       win,
  output logic [3:0] starve_cnt
);

  localparam logic [3:0] SAT = 4'(MAX_WAIT);

  always_comb begin
    win = M_CPU;
    case (req)
      2'b10:   win = M_DMA;
      2'b11:   win = (starve_cnt == SAT) ? M_DMA : M_CPU;
      default: win = M_CPU;
    endcase
  end

  // Counts only contested m0 wins; any IDLE cycle without m1 pending forgets the history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (fire) begin
      if (!req[1] || win == M_DMA) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SAT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mio_ram_arbiter.sv
// Two-master single-port data-RAM arbiter: one transaction at a time, fixed RAM read latency.
module mio_ram_arbiter
  import mio_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_be,
  output logic            m0_gnt,
  output logic            m0_ack,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_be,
  output logic            m1_gnt,
  output logic            m1_ack,
  output logic [DW-1:0]   m1_rdata,
  output logic [AW-1:0]   ram_addr,
  output logic [DW/8-1:0] ram_we,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata,
  output logic            busy,
  output logic            owner
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(1);

  arb_state_t    state, state_nxt;
  logic [CW-1:0] lat_cnt;
  logic          we_q;
  logic [BW-1:0] be_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          owner_q;
  logic          win;
  logic [3:0]    starve_cnt;
  logic          fire;
  logic          capture;
  logic          ack_now;

  assign fire = (state == IDLE);

  mio_arb_prio #(.MAX_WAIT(MAX_WAIT)) u_prio (
    .clk        (clk),
    .rst        (rst),
    .req        ({m1_req, m0_req}),
    .fire       (fire),
    .win        (win),
    .starve_cnt (starve_cnt)
  );

  assert property (@(posedge clk) disable iff (rst) starve_cnt <= 4'(MAX_WAIT));

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:  if (m0_req || m1_req) state_nxt = ISSUE;
      ISSUE: begin
        if (we_q) begin
          state_nxt = IDLE;
        end else if (RD_LAT == 1) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    ack_now   = (state == ISSUE && we_q) || (state == RESP);
    m0_gnt    = busy && (owner_q == M_CPU);
    m1_gnt    = busy && (owner_q == M_DMA);
    m0_ack    = ack_now && (owner_q == M_CPU);
    m1_ack    = ack_now && (owner_q == M_DMA);
    ram_we    = (state == ISSUE && we_q) ? be_q : '0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    m0_rdata  = rdata_q;
    m1_rdata  = rdata_q;
    owner     = owner_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ISSUE) begin
        lat_cnt <= LAT_LOAD;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - LAT_LAST;
      end
    end
  end

  // Command is frozen at the IDLE edge so later changes on the master side cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= M_CPU;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (fire && (m0_req || m1_req)) begin
      owner_q <= win;
      if (win == M_DMA) begin
        we_q    <= m1_we;
        be_q    <= m1_be;
        addr_q  <= m1_addr;
        wdata_q <= m1_wdata;
      end else begin
        we_q    <= m0_we;
        be_q    <= m0_be;
        addr_q  <= m0_addr;
        wdata_q <= m0_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (capture) begin
      rdata_q <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_mio_ram_arbiter.sv
// Bench for mio_ram_arbiter: directed scenarios on RD_LAT=1 and RD_LAT=3 instances plus random traffic.
module tb_mio_ram_arbiter;

  localparam int MAX_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;

  logic        a_m0_gnt, a_m0_ack, a_m1_gnt, a_m1_ack, a_busy, a_owner;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_ram_addr, a_ram_wdata, a_ram_rdata;
  logic [3:0]  a_ram_we;
  logic        b_m0_gnt, b_m0_ack, b_m1_gnt, b_m1_ack, b_busy, b_owner;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic [3:0]  b_ram_we;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] b_d1, b_d2;
  logic        pl_en, pl_sel;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mio_ram_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .MAX_WAIT(MAX_WAIT)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(a_m0_gnt), .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(a_m1_gnt), .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
    .ram_addr(a_ram_addr), .ram_we(a_ram_we), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata),
    .busy(a_busy), .owner(a_owner)
  );

  mio_ram_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_WAIT(MAX_WAIT)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(b_m0_gnt), .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(b_m1_gnt), .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
    .busy(b_busy), .owner(b_owner)
  );

  // RAM models: instance a reads combinationally, instance b delivers data 3 cycles after the address.
  always @(posedge clk) begin
    if (pl_en) begin
      if (pl_sel) mem_b[pl_addr] <= pl_data;
      else        mem_a[pl_addr] <= pl_data;
    end
    for (int i = 0; i < 4; i++) begin
      if (a_ram_we[i]) mem_a[a_ram_addr[7:0]][i*8 +: 8] <= a_ram_wdata[i*8 +: 8];
      if (b_ram_we[i]) mem_b[b_ram_addr[7:0]][i*8 +: 8] <= b_ram_wdata[i*8 +: 8];
    end
    b_d1 <= mem_b[b_ram_addr[7:0]];
    b_d2 <= b_d1;
  end

  assign a_ram_rdata = mem_a[a_ram_addr[7:0]];
  assign b_ram_rdata = b_d2;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
  endtask

  task automatic settle();
    idle_inputs();
    repeat (6) cyc();
  endtask

  task automatic preload(input logic sel, input logic [7:0] addr, input logic [31:0] data);
    pl_sel = sel; pl_addr = addr; pl_data = data; pl_en = 1'b1;
    cyc();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pl_en = 1'b0;
    idle_inputs();
    repeat (2) cyc();
    total++; if ({a_m0_gnt, a_m0_ack, a_m1_gnt, a_m1_ack, a_busy, a_owner} !== 6'b0) $display("FAIL reset_a_ctrl: got %b want 000000", {a_m0_gnt, a_m0_ack, a_m1_gnt, a_m1_ack, a_busy, a_owner}); else passed++;
    total++; if ({b_m0_gnt, b_m0_ack, b_m1_gnt, b_m1_ack, b_busy, b_owner} !== 6'b0) $display("FAIL reset_b_ctrl: got %b want 000000", {b_m0_gnt, b_m0_ack, b_m1_gnt, b_m1_ack, b_busy, b_owner}); else passed++;
    total++; if (a_ram_we !== 4'b0 || b_ram_we !== 4'b0) $display("FAIL reset_ram_we: got %h/%h want 0/0", a_ram_we, b_ram_we); else passed++;
    total++; if (a_ram_addr !== 32'h0 || a_ram_wdata !== 32'h0) $display("FAIL reset_ram_cmd: got %h/%h want 0/0", a_ram_addr, a_ram_wdata); else passed++;
    total++; if (a_m0_rdata !== 32'h0 || b_m1_rdata !== 32'h0) $display("FAIL reset_rdata: got %h/%h want 0/0", a_m0_rdata, b_m1_rdata); else passed++;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_read_basic();
    preload(1'b0, 8'h10, 32'hDEADBEEF);
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    cyc();
    total++; if (a_m0_gnt !== 1'b1 || a_m1_gnt !== 1'b0) $display("FAIL rd_gnt: got m0=%b m1=%b want 1/0", a_m0_gnt, a_m1_gnt); else passed++;
    total++; if (a_ram_addr !== 32'h10) $display("FAIL rd_addr: got %h want 00000010", a_ram_addr); else passed++;
    total++; if (a_m0_ack !== 1'b0 || a_ram_we !== 4'b0) $display("FAIL rd_early: got ack=%b we=%h want 0/0", a_m0_ack, a_ram_we); else passed++;
    cyc();
    total++; if (a_m0_ack !== 1'b1 || a_m1_ack !== 1'b0) $display("FAIL rd_ack: got m0=%b m1=%b want 1/0", a_m0_ack, a_m1_ack); else passed++;
    total++; if (a_m0_rdata !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", a_m0_rdata); else passed++;
    m0_req = 0;
    cyc();
    total++; if (a_m0_ack !== 1'b0 || a_busy !== 1'b0) $display("FAIL rd_after: got ack=%b busy=%b want 0/0", a_m0_ack, a_busy); else passed++;
    total++; if (a_ram_addr !== 32'h10) $display("FAIL rd_addr_hold: got %h want 00000010", a_ram_addr); else passed++;
    settle();
  endtask

  task automatic test_write_basic();
    preload(1'b0, 8'h20, 32'hAAAAAAAA);
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678; m1_be = 4'b0011;
    cyc();
    total++; if (a_ram_we !== 4'b0011) $display("FAIL wr_we: got %b want 0011", a_ram_we); else passed++;
    total++; if ({a_m1_gnt, a_m1_ack, a_m0_gnt, a_owner} !== 4'b1101) $display("FAIL wr_ack: got %b want 1101", {a_m1_gnt, a_m1_ack, a_m0_gnt, a_owner}); else passed++;
    total++; if (a_ram_wdata !== 32'h12345678) $display("FAIL wr_wdata: got %h want 12345678", a_ram_wdata); else passed++;
    m1_req = 0;
    cyc();
    total++; if (a_ram_we !== 4'b0 || a_busy !== 1'b0 || a_m1_ack !== 1'b0) $display("FAIL wr_after: got we=%b busy=%b ack=%b want 0/0/0", a_ram_we, a_busy, a_m1_ack); else passed++;
    total++; if (mem_a[8'h20] !== 32'hAAAA5678) $display("FAIL wr_mem: got %h want aaaa5678", mem_a[8'h20]); else passed++;
    settle();
  endtask

  task automatic test_be_zero();
    preload(1'b0, 8'h30, 32'h55555555);
    m1_req = 1; m1_we = 1; m1_addr = 32'h30; m1_wdata = 32'hFFFFFFFF; m1_be = 4'b0000;
    cyc();
    total++; if (a_ram_we !== 4'b0 || a_m1_ack !== 1'b1) $display("FAIL be0_issue: got we=%b ack=%b want 0000/1", a_ram_we, a_m1_ack); else passed++;
    m1_req = 0;
    repeat (2) cyc();
    total++; if (mem_a[8'h30] !== 32'h55555555) $display("FAIL be0_mem: got %h want 55555555", mem_a[8'h30]); else passed++;
    settle();
  endtask

  task automatic test_starvation();
    int cnt = 0;
    int got = 0;
    logic [1:0] exp_ack;
    m0_req = 1; m0_we = 1; m0_addr = 32'h50; m0_wdata = 32'h1; m0_be = 4'hF;
    m1_req = 1; m1_we = 1; m1_addr = 32'h54; m1_wdata = 32'h2; m1_be = 4'hF;
    for (int k = 0; k < 60 && got < 8; k++) begin
      cyc();
      if (a_m0_ack || a_m1_ack) begin
        if (cnt == MAX_WAIT) begin exp_ack = 2'b10; cnt = 0; end
        else begin exp_ack = 2'b01; cnt++; end
        total++; if ({a_m1_ack, a_m0_ack} !== exp_ack) $display("FAIL starve_grant%0d: got {m1,m0}=%b want %b", got, {a_m1_ack, a_m0_ack}, exp_ack); else passed++;
        got++;
      end
    end
    total++; if (got != 8) $display("FAIL starve_count: got %0d acks want 8", got); else passed++;
    settle();
  endtask

  task automatic test_drop_in_wait();
    int m1_seen = 0;
    int we_seen = 0;
    int ack_cyc = -1;
    logic [31:0] rd = '0;
    preload(1'b1, 8'h60, 32'hCAFEF00D);
    m0_req = 1; m0_we = 0; m0_addr = 32'h60;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (b_m1_gnt || b_m1_ack) m1_seen++;
      if (b_ram_we != 4'b0) we_seen++;
      if (b_m0_ack && ack_cyc < 0) begin ack_cyc = k; rd = b_m0_rdata; m0_req = 0; end
      if (k == 2) begin m1_req = 1; m1_we = 1; m1_addr = 32'h64; m1_wdata = 32'h77; m1_be = 4'hF; end
      if (k == 3) m1_req = 0;
    end
    total++; if (m1_seen != 0) $display("FAIL pulse_m1: got %0d m1 gnt/ack cycles want 0", m1_seen); else passed++;
    total++; if (we_seen != 0) $display("FAIL pulse_we: got %0d write cycles want 0", we_seen); else passed++;
    total++; if (ack_cyc != 4) $display("FAIL pulse_rd_ack: got cycle %0d want 4", ack_cyc); else passed++;
    total++; if (rd !== 32'hCAFEF00D) $display("FAIL pulse_rd_data: got %h want cafef00d", rd); else passed++;
    settle();
  endtask

  task automatic lat3_read(input string tag, input logic [31:0] addr, input logic [31:0] want);
    int ack_cyc = -1;
    logic [31:0] rd = '0;
    m0_req = 1; m0_we = 0; m0_addr = addr;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (b_m0_ack && ack_cyc < 0) begin ack_cyc = k; rd = b_m0_rdata; m0_req = 0; end
    end
    total++; if (ack_cyc != 4) $display("FAIL %s_ack: got cycle %0d want 4", tag, ack_cyc); else passed++;
    total++; if (rd !== want) $display("FAIL %s_data: got %h want %h", tag, rd, want); else passed++;
    settle();
  endtask

  task automatic test_latency_reset();
    int acks = 0;
    preload(1'b1, 8'h70, 32'h0BADF00D);
    preload(1'b1, 8'h74, 32'h13579BDF);
    lat3_read("lat3_first", 32'h70, 32'h0BADF00D);
    m0_req = 1; m0_we = 0; m0_addr = 32'h74;
    repeat (2) cyc();
    total++; if (b_busy !== 1'b1 || b_m0_gnt !== 1'b1) $display("FAIL rstw_pre: got busy=%b gnt=%b want 1/1", b_busy, b_m0_gnt); else passed++;
    rst = 1'b1;
    #1;
    total++; if ({b_m0_gnt, b_m0_ack, b_busy, b_ram_we} !== 7'b0) $display("FAIL rstw_now: got %b want 0000000", {b_m0_gnt, b_m0_ack, b_busy, b_ram_we}); else passed++;
    m0_req = 0;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (b_m0_ack || b_m1_ack) acks++;
    end
    total++; if (acks != 0) $display("FAIL rstw_noack: got %0d acks want 0", acks); else passed++;
    lat3_read("lat3_after", 32'h74, 32'h13579BDF);
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [8];
    logic        cmd_we  [2];
    logic [2:0]  cmd_idx [2];
    logic [31:0] cmd_wd  [2];
    logic [3:0]  cmd_be  [2];
    logic [1:0]  pat;
    logic [31:0] rd;
    int          starve = 0;
    int          exp_q[$];
    int          w, bad;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = $urandom;
      preload(1'b0, 8'h80 + 8'(i), ref_mem[i]);
    end
    for (int it = 0; it < 40; it++) begin
      pat = 2'($urandom_range(1, 3));
      for (int m = 0; m < 2; m++) begin
        cmd_we[m]  = 1'($urandom_range(0, 1));
        cmd_idx[m] = 3'($urandom_range(0, 7));
        cmd_wd[m]  = $urandom;
        cmd_be[m]  = 4'($urandom_range(0, 15));
      end
      m0_we = cmd_we[0]; m0_addr = 32'h80 + 32'(cmd_idx[0]); m0_wdata = cmd_wd[0]; m0_be = cmd_be[0];
      m1_we = cmd_we[1]; m1_addr = 32'h80 + 32'(cmd_idx[1]); m1_wdata = cmd_wd[1]; m1_be = cmd_be[1];
      // Expected service order from the priority/starvation rule.
      if (pat == 2'b11) begin
        if (starve == MAX_WAIT) begin
          exp_q.push_back(1); exp_q.push_back(0); starve = 0;
        end else begin
          exp_q.push_back(0); exp_q.push_back(1); starve = 0;
        end
      end else begin
        exp_q.push_back(pat == 2'b10 ? 1 : 0);
        starve = 0;
      end
      m0_req = pat[0]; m1_req = pat[1];
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
        cyc();
        if (a_m0_ack || a_m1_ack) begin
          w = exp_q.pop_front();
          total++; if ({a_m1_ack, a_m0_ack} !== (w == 1 ? 2'b10 : 2'b01)) $display("FAIL rnd_order it%0d: got {m1,m0}=%b want m%0d", it, {a_m1_ack, a_m0_ack}, w); else passed++;
          if (!cmd_we[w]) begin
            rd = (w == 1) ? a_m1_rdata : a_m0_rdata;
            total++; if (rd !== ref_mem[cmd_idx[w]]) $display("FAIL rnd_rdata it%0d: got %h want %h", it, rd, ref_mem[cmd_idx[w]]); else passed++;
          end else begin
            for (int b = 0; b < 4; b++)
              if (cmd_be[w][b]) ref_mem[cmd_idx[w]][b*8 +: 8] = cmd_wd[w][b*8 +: 8];
          end
          if (a_m0_ack) m0_req = 0;
          if (a_m1_ack) m1_req = 0;
        end
      end
      if (exp_q.size() > 0) begin
        total++; $display("FAIL rnd_timeout it%0d: got %0d pending acks want 0", it, exp_q.size());
        exp_q.delete();
      end
      m0_req = 0; m1_req = 0;
      cyc();
    end
    bad = 0;
    for (int i = 0; i < 8; i++) if (mem_a[8'h80 + 8'(i)] !== ref_mem[i]) bad++;
    total++; if (bad != 0) $display("FAIL rnd_mem: got %0d differing words want 0", bad); else passed++;
    settle();
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_be_zero();
    test_starvation();
    test_drop_in_wait();
    test_latency_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
